// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared types for the pipeline hazard controller: forwarding selects,
// FSM states and the per-stage destination shadow slot.
package pipeline_hazard_ctrl_pkg;

  localparam int RA_W = 5;

  localparam logic [1:0] FWD_REG   = 2'b00;
  localparam logic [1:0] FWD_EXMEM = 2'b01;
  localparam logic [1:0] FWD_MEMWB = 2'b10;

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_LU_STALL = 2'd1,
    ST_MEM_WAIT = 2'd2
  } state_e;

  typedef struct packed {
    logic            valid;
    logic [RA_W-1:0] rd;
    logic            we;
    logic            load;
  } slot_t;

  // x0 is hardwired, so a slot targeting it never produces a value.
  function automatic logic slot_writes(slot_t s, logic [RA_W-1:0] r);
    return s.valid && s.we && (s.rd == r) && (r != '0);
  endfunction

endpackage

// File: rtl/pipeline_hazard_ctrl_if.sv
// Decoder/pipeline-side bundle of the hazard controller.
interface pipeline_hazard_ctrl_if #(
  parameter int REG_W = 5,
  parameter int CNT_W = 32
);
  logic             id_valid;
  logic [REG_W-1:0] id_rs1;
  logic [REG_W-1:0] id_rs2;
  logic             id_use_rs1;
  logic             id_use_rs2;
  logic [REG_W-1:0] id_rd;
  logic             id_we;
  logic             id_load;
  logic             ex_branch_taken;
  logic             mem_busy;
  logic             pc_en;
  logic             ifid_en;
  logic             ifid_flush;
  logic             idex_en;
  logic             idex_flush;
  logic             exmem_en;
  logic [1:0]       fwd_a;
  logic [1:0]       fwd_b;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;

  modport master (
    output id_valid, id_rs1, id_rs2, id_use_rs1, id_use_rs2, id_rd, id_we, id_load,
    output ex_branch_taken, mem_busy,
    input  pc_en, ifid_en, ifid_flush, idex_en, idex_flush, exmem_en,
    input  fwd_a, fwd_b, stall_cnt, flush_cnt
  );

  modport slave (
    input  id_valid, id_rs1, id_rs2, id_use_rs1, id_use_rs2, id_rd, id_we, id_load,
    input  ex_branch_taken, mem_busy,
    output pc_en, ifid_en, ifid_flush, idex_en, idex_flush, exmem_en,
    output fwd_a, fwd_b, stall_cnt, flush_cnt
  );
endinterface

// File: rtl/pipeline_hazard_ctrl_hazard_fwd_sel.sv
// Per-operand forwarding select: the nearest older producer wins.
module hazard_fwd_sel
  import pipeline_hazard_ctrl_pkg::*;
(
  input  logic [RA_W-1:0] rs_i,
  input  logic            use_i,
  input  slot_t           ex_s_i,
  input  slot_t           mem_s_i,
  output logic [1:0]      sel_o
);

  always_comb begin
    sel_o = FWD_REG;
    if (use_i) begin
      if (slot_writes(ex_s_i, rs_i)) begin
        sel_o = FWD_EXMEM;
      end else if (slot_writes(mem_s_i, rs_i)) begin
        sel_o = FWD_MEMWB;
      end
    end
  end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Hazard controller for the 5-stage RV32I pipeline: load-use stall, branch
// flush, memory freeze, registered EX forwarding selects and event counters.
//
//   state     | meaning
//   RUN       | normal flow
//   LU_STALL  | one bubble inserted behind a load; load now in MEM
//   MEM_WAIT  | data memory busy, whole pipeline frozen
module pipeline_hazard_ctrl
  import pipeline_hazard_ctrl_pkg::*;
#(
  parameter int REG_W = RA_W,
  parameter int CNT_W = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  pipeline_hazard_ctrl_if.slave bus
);

  state_e           state_q, state_d;
  slot_t            ex_q, mem_q, wb_q;
  slot_t            id_slot;
  logic [1:0]       fwd_a_q, fwd_b_q;
  logic [1:0]       sel_a, sel_b;
  logic [CNT_W-1:0] stall_q, flush_q;
  logic             lu;
  logic             bubble;
  logic             stall_evt;
  logic             flush_evt;

  assign id_slot = '{valid: 1'b1, rd: bus.id_rd, we: bus.id_we, load: bus.id_load};

  assign lu = bus.id_valid && ex_q.load &&
              ((bus.id_use_rs1 && slot_writes(ex_q, bus.id_rs1)) ||
               (bus.id_use_rs2 && slot_writes(ex_q, bus.id_rs2)));

  assign bubble    = bus.ex_branch_taken || lu || !bus.id_valid;
  assign stall_evt = lu && !bus.ex_branch_taken && !bus.mem_busy;
  assign flush_evt = bus.ex_branch_taken && !bus.mem_busy;

  hazard_fwd_sel u_sel_a (
    .rs_i    (bus.id_rs1),
    .use_i   (bus.id_use_rs1),
    .ex_s_i  (ex_q),
    .mem_s_i (mem_q),
    .sel_o   (sel_a)
  );

  hazard_fwd_sel u_sel_b (
    .rs_i    (bus.id_rs2),
    .use_i   (bus.id_use_rs2),
    .ex_s_i  (ex_q),
    .mem_s_i (mem_q),
    .sel_o   (sel_b)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_RUN;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    bus.pc_en      = 1'b1;
    bus.ifid_en    = 1'b1;
    bus.ifid_flush = 1'b0;
    bus.idex_en    = 1'b1;
    bus.idex_flush = 1'b0;
    bus.exmem_en   = 1'b1;

    if (bus.mem_busy) begin
      state_d = ST_MEM_WAIT;
    end else begin
      unique case (state_q)
        ST_RUN:      if (lu && !bus.ex_branch_taken) state_d = ST_LU_STALL;
        ST_LU_STALL: state_d = ST_RUN;
        ST_MEM_WAIT: state_d = ST_RUN;
        default:     state_d = ST_RUN;
      endcase
    end

    // Outputs follow the live inputs; reset low keeps the pipeline flowing.
    if (reset) begin
      if (bus.mem_busy) begin
        bus.pc_en    = 1'b0;
        bus.ifid_en  = 1'b0;
        bus.idex_en  = 1'b0;
        bus.exmem_en = 1'b0;
      end else if (bus.ex_branch_taken) begin
        bus.ifid_flush = 1'b1;
        bus.idex_flush = 1'b1;
      end else if (lu) begin
        bus.pc_en      = 1'b0;
        bus.ifid_en    = 1'b0;
        bus.idex_flush = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ex_q    <= '0;
      mem_q   <= '0;
      wb_q    <= '0;
      fwd_a_q <= FWD_REG;
      fwd_b_q <= FWD_REG;
    end else if (!bus.mem_busy) begin
      wb_q    <= mem_q;
      mem_q   <= ex_q;
      ex_q    <= bubble ? slot_t'('0) : id_slot;
      fwd_a_q <= bubble ? FWD_REG : sel_a;
      fwd_b_q <= bubble ? FWD_REG : sel_b;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      if (stall_evt && (stall_q != '1)) stall_q <= stall_q + CNT_W'(1);
      if (flush_evt && (flush_q != '1)) flush_q <= flush_q + CNT_W'(1);
    end
  end

  assign bus.fwd_a     = fwd_a_q;
  assign bus.fwd_b     = fwd_b_q;
  assign bus.stall_cnt = stall_q;
  assign bus.flush_cnt = flush_q;

  // The stalling load has reached MEM, so a second load-use here is impossible.
  a_no_double_lu: assert property (@(posedge clk) disable iff (!reset)
    !(state_q == ST_LU_STALL && lu));

  a_load_drains: assert property (@(posedge clk) disable iff (!reset)
    (state_q == ST_LU_STALL && !bus.mem_busy) |=> (wb_q.valid && wb_q.load));

endmodule
